val_buffer: RTL and testbench
=============================

# val_buffer

Upstream framing stage for `val_find`. Accepts a stream of 4-bit samples over a valid/ready handshake and packs eight of them into one frame register. It presents that frame, held stable, to the max/index finder until the finder acknowledges it, then starts the next frame. Arrival order defines element index, so the finder's reported index equals the sample's position in the input stream.

## Interface
Parameters:
- `WIDTH`, 4: sample width in bits.
- `DEPTH`, 8: samples per frame.
- `IDX_W`, 3: index width; equals clog2(`DEPTH`).

Ports:
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  upstream sample valid.
- `i_data`  in  `WIDTH`  upstream sample.
- `o_ready`  out  1  buffer can accept a sample this cycle.
- `i_flush`  in  1  synchronous discard of the current frame (partial or full).
- `o_frame`  out  `DEPTH*WIDTH`  packed frame; element k at bits [k*WIDTH +: WIDTH].
- `o_frame_valid`  out  1  frame complete and stable.
- `i_frame_ack`  in  1  finder has consumed the frame.
- `o_count`  out  `IDX_W+1`  samples accepted into the current frame (0..`DEPTH`).

## Operation
- Two states: FILL and FULL. State is registered.
- **Reset:** state FILL, `o_count`=0, write pointer 0, `o_frame`=0, `o_frame_valid`=0, `o_ready`=1.
- **FILL:**
  - `o_ready`=1 and `o_frame_valid`=0.
  - Accept occurs when `i_valid` and `o_ready` are both 1. On accept, `i_data` is written to element [`o_count`] and `o_count` increments.
  - The accept that brings `o_count` to `DEPTH` moves the state to FULL.
- **FULL:**
  - `o_ready`=0 and `o_frame_valid`=1. `o_frame` is frozen and `o_count`=`DEPTH`.
  - `i_frame_ack`=1 moves the state to FILL and sets `o_count`=0.
- **Stale data:** element contents are not cleared between frames. Stale elements sit above `o_count` and are never flagged valid.
- **`i_flush`:** has priority over everything else in either state. It forces FILL and `o_count`=0. A sample presented in the same cycle is dropped, and an ack in the same cycle is irrelevant.
- **`i_frame_ack` in FILL:** ignored, with no side effects.
- **`i_valid` in FULL:** no accept (`o_ready`=0). Upstream must hold the sample.
- **Simultaneous 8th accept and ack:** not possible, because ack is only meaningful in FULL.
- **Reset mid-frame:** asynchronous clear to reset values. A partial frame is lost.
- **Arithmetic:** `o_count` is unsigned `IDX_W+1` bits. The write pointer is the low `IDX_W` bits of `o_count`, so there is no wrap within a frame. `o_count` never exceeds `DEPTH`.

## Timing
- `o_ready` and `o_frame_valid` are decoded from the registered state only. There is no combinational path from any input to any output.
- Latency: `o_frame_valid` rises on the edge that captures the 8th sample, so it is visible in the cycle after that accept.
- Ack turnaround: `i_frame_ack` sampled high at edge N gives `o_ready`=1 in cycle N+1.
- Maximum throughput: one frame per `DEPTH`+1 cycles, with continuous `i_valid` and an ack on the first FULL cycle.
- `o_frame` changes only on an accept edge in FILL. It is bit-stable across every FULL cycle.

## Structure
- Shared package `val_pkg`:
  - `VAL_WIDTH`=4, `VAL_DEPTH`=8, `VAL_IDX_W`=3. The same constants are used by `val_find`.
  - State enum `val_buf_state_t` {FILL, FULL}.
- No sub-module is needed. The element store is a `DEPTH`x`WIDTH` register array with a single write port, flattened onto `o_frame`.

## Test plan
1. **Reset values:** hold `i_rst_n`=0 with random inputs. Expect `o_ready`=1, `o_frame_valid`=0, `o_count`=0, `o_frame`=0. Assert reset asynchronously between edges; outputs clear immediately.
2. **Full frame, back-to-back:** feed 3,9,1,15,0,7,15,2 with `i_valid` held high. Expect `o_frame`=32'h2F70_F193 and `o_frame_valid`=1 on the 9th cycle. Ack there; `o_ready`=1 next cycle.
3. **Backpressure:** complete a frame and hold `i_valid`=1 with `i_data`=4'hA and no ack for 5 cycles. Expect the frame unchanged and `o_count`=8. After ack, 4'hA is accepted as element 0 of the next frame.
4. **Flush:**
   - After 5 accepts, pulse `i_flush` together with `i_valid` (data 4'h6). Expect `o_count`=0 and the 4'h6 dropped.
   - Flush in FULL: expect `o_frame_valid`=0 next cycle.
5. **Spurious ack and gaps:** pulse `i_frame_ack` during FILL, and toggle `i_valid` with idle gaps. Expect `o_count` to increment only on accepts and the ack to have no effect.
6. **Reset mid-frame:** assert `i_rst_n`=0 after 4 accepts, then release. Expect `o_count`=0. The next 8 samples form a valid frame with no residue from the first 4.

Source files
------------

// File: rtl/val_pkg.sv
// Shared constants and state type for the val_buffer / val_find pair.
package val_pkg;
  localparam int VAL_WIDTH = 4;
  localparam int VAL_DEPTH = 8;
  localparam int VAL_IDX_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } val_buf_state_t;
endpackage : val_pkg

// File: rtl/val_buffer_if.sv
// Sample-in / frame-out handshake bundle between the upstream source, val_buffer and the finder.
interface val_buffer_if
  import val_pkg::*;
#(
  parameter int WIDTH = VAL_WIDTH,
  parameter int DEPTH = VAL_DEPTH,
  parameter int IDX_W = VAL_IDX_W
);
  logic                   i_valid;
  logic [WIDTH-1:0]       i_data;
  logic                   o_ready;
  logic                   i_flush;
  logic [DEPTH*WIDTH-1:0] o_frame;
  logic                   o_frame_valid;
  logic                   i_frame_ack;
  logic [IDX_W:0]         o_count;

  modport master (
    output i_valid, i_data, i_flush, i_frame_ack,
    input  o_ready, o_frame, o_frame_valid, o_count
  );

  modport slave (
    input  i_valid, i_data, i_flush, i_frame_ack,
    output o_ready, o_frame, o_frame_valid, o_count
  );
endinterface : val_buffer_if

// File: rtl/val_buffer.sv
// Packs DEPTH incoming samples into one frame and holds it stable until the finder acks it.
module val_buffer
  import val_pkg::*;
#(
  parameter int WIDTH = VAL_WIDTH,
  parameter int DEPTH = VAL_DEPTH,
  parameter int IDX_W = VAL_IDX_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  val_buffer_if.slave  bus
);
  localparam logic [IDX_W:0] CNT_ZERO = (IDX_W + 1)'(0);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0] CNT_LAST = (IDX_W + 1)'(DEPTH - 1);

  val_buf_state_t   state_r;
  logic [IDX_W:0]   count_r;
  logic             ready_r;
  logic             frame_valid_r;
  logic [WIDTH-1:0] elem_r [DEPTH];

  // Frame FSM: flush overrides everything; elements are never cleared between frames.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= FILL;
      count_r       <= CNT_ZERO;
      ready_r       <= 1'b1;
      frame_valid_r <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        elem_r[k] <= {WIDTH{1'b0}};
      end
    end else if (bus.i_flush) begin
      state_r       <= FILL;
      count_r       <= CNT_ZERO;
      ready_r       <= 1'b1;
      frame_valid_r <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (bus.i_valid) begin
            elem_r[count_r[IDX_W-1:0]] <= bus.i_data;
            count_r                    <= count_r + CNT_ONE;
            if (count_r == CNT_LAST) begin
              state_r       <= FULL;
              ready_r       <= 1'b0;
              frame_valid_r <= 1'b1;
            end else begin
              state_r       <= FILL;
              ready_r       <= 1'b1;
              frame_valid_r <= 1'b0;
            end
          end else begin
            state_r <= FILL;
          end
        end
        FULL: begin
          if (bus.i_frame_ack) begin
            state_r       <= FILL;
            count_r       <= CNT_ZERO;
            ready_r       <= 1'b1;
            frame_valid_r <= 1'b0;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r       <= FILL;
          count_r       <= CNT_ZERO;
          ready_r       <= 1'b1;
          frame_valid_r <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flatten
    assign bus.o_frame[k*WIDTH +: WIDTH] = elem_r[k];
  end

  assign bus.o_ready       = ready_r;
  assign bus.o_frame_valid = frame_valid_r;
  assign bus.o_count       = count_r;
endmodule : val_buffer

// File: tb/tb_val_buffer.sv
// Directed plus randomized checks of val_buffer against a queue-based frame model.
module tb_val_buffer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  val_buffer_if bus ();

  val_buffer u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: samples of the current frame in arrival order, plus the last value written per slot.
  int        frame_q [$];
  logic [3:0] slot [8];

  function automatic logic [31:0] exp_frame();
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = slot[k];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit full;
    full = (frame_q.size() == 8);
    check({tag, ".ready"}, {31'h0, bus.o_ready}, {31'h0, !full});
    check({tag, ".fvalid"}, {31'h0, bus.o_frame_valid}, {31'h0, full});
    check({tag, ".count"}, {28'h0, bus.o_count}, frame_q.size());
    check({tag, ".frame"}, bus.o_frame, exp_frame());
  endtask

  task automatic model_reset();
    frame_q.delete();
    for (int k = 0; k < 8; k++) slot[k] = 4'h0;
  endtask

  // One clock: drive, advance the model with pre-edge state, compare just after the edge.
  task automatic step(input string tag, input logic v, input logic [3:0] d,
                      input logic f, input logic a);
    bit full;
    bus.i_valid     = v;
    bus.i_data      = d;
    bus.i_flush     = f;
    bus.i_frame_ack = a;
    full = (frame_q.size() == 8);
    @(posedge clk);
    if (f) frame_q.delete();
    else if (full) begin
      if (a) frame_q.delete();
    end else if (v) begin
      slot[frame_q.size()] = d;
      frame_q.push_back(int'(d));
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] seq [8];
    checks = 0;
    errors = 0;
    seq = '{4'd3, 4'd9, 4'd1, 4'd15, 4'd0, 4'd7, 4'd15, 4'd2};
    model_reset();

    rst_n           = 1'b0;
    bus.i_valid     = 1'($urandom);
    bus.i_data      = 4'($urandom);
    bus.i_flush     = 1'($urandom);
    bus.i_frame_ack = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    #2 rst_n = 1'b1;

    // Back-to-back known frame, ack on first FULL cycle.
    for (int i = 0; i < 8; i++) step("b2b", 1'b1, seq[i], 1'b0, 1'b0);
    check("b2b.const", bus.o_frame, 32'h2F70_F193);
    step("b2b.ack", 1'b1, 4'h5, 1'b0, 1'b1);
    check("b2b.ready_after_ack", {31'h0, bus.o_ready}, 32'h1);

    // Backpressure with a held sample.
    for (int i = 1; i < 8; i++) step("bp.fill", 1'b1, 4'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("bp.hold", 1'b1, 4'hA, 1'b0, 1'b0);
    step("bp.ack", 1'b1, 4'hA, 1'b0, 1'b1);
    step("bp.take", 1'b1, 4'hA, 1'b0, 1'b0);
    check("bp.elem0", {28'h0, bus.o_frame[3:0]}, 32'hA);

    // Flush partial frame with a concurrent sample, then flush a full frame.
    for (int i = 1; i < 5; i++) step("fl.fill", 1'b1, 4'($urandom), 1'b0, 1'b0);
    step("fl.partial", 1'b1, 4'h6, 1'b1, 1'b0);
    check("fl.count0", {28'h0, bus.o_count}, 32'h0);
    for (int i = 0; i < 8; i++) step("fl.fill2", 1'b1, 4'($urandom), 1'b0, 1'b0);
    step("fl.full", 1'b0, 4'h0, 1'b1, 1'b1);
    check("fl.fvalid0", {31'h0, bus.o_frame_valid}, 32'h0);

    // Spurious acks during FILL with idle gaps.
    for (int i = 0; i < 20; i++)
      step("gap", 1'($urandom), 4'($urandom), 1'b0, (frame_q.size() < 8) ? 1'b1 : 1'($urandom));

    // Reset mid-frame: asserted between edges, takes effect immediately.
    step("rm.idle", 1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("rm.fill", 1'b1, 4'($urandom_range(1, 15)), 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rm.async");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step("rm.refill", 1'b1, 4'($urandom), 1'b0, 1'b0);
    step("rm.ack", 1'b0, 4'h0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 9) < 7), 4'($urandom),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule : tb_val_buffer
